// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Drives the single write port of the 32x32 register file from two sources:
// the in-order pipeline writeback (priority, no handshake) and a long-latency
// unit (valid/ready handshake into a small FIFO). Pending FIFO entries and the
// output register are visible through two forwarding lookup ports.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   pipe_valid/rd/data         pipeline writeback request (must be taken)
//   pipe_stall                 upstream must hold pipe_valid=0 this cycle
//   ll_valid/ready/rd/data     long-latency request handshake
//   regWrite/rd/writeData      registered register-file write port
//   fwd_rs/rt                  forwarding lookup addresses
//   fwd_*_hit/data             forwarding results
//   pending_count              FIFO occupancy (alive + dead entries)
//   err_sticky                 a pipe write was presented during pipe_stall
//
// Handshake: an ll transfer happens on a rising edge where ll_valid and
// ll_ready are both 1; ll_ready depends only on registered occupancy.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int AW           = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_valid,
  input  logic [4:0]    pipe_rd,
  input  logic [31:0]   pipe_data,
  output logic          pipe_stall,
  input  logic          ll_valid,
  output logic          ll_ready,
  input  logic [4:0]    ll_rd,
  input  logic [31:0]   ll_data,
  output logic          regWrite,
  output logic [4:0]    rd,
  output logic [31:0]   writeData,
  input  logic [4:0]    fwd_rs,
  input  logic [4:0]    fwd_rt,
  output logic          fwd_rs_hit,
  output logic          fwd_rt_hit,
  output logic [31:0]   fwd_rs_data,
  output logic [31:0]   fwd_rt_data,
  output logic [AW:0]   pending_count,
  output logic          err_sticky
);

  localparam int GW = $clog2(STARVE_LIMIT + 1);

  // FIFO storage and pointers
  logic [DEPTH-1:0] alive_q, alive_d;
  logic [4:0]       ent_rd_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]      count_q, count_d;
  logic [GW-1:0]    age_q, age_d;

  // Output stage
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_rd_q, wr_rd_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             err_q, err_d;

  logic empty, full, pipe_issue, pop, push;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign ll_ready   = !full;
  assign pipe_stall = !empty && (age_q == GW'(STARVE_LIMIT));

  // A stall forces a pop; any pipe_valid (even to r0) otherwise owns the
  // port and blocks the FIFO that cycle.
  assign pipe_issue = !pipe_stall && pipe_valid && (pipe_rd != 5'd0);
  assign pop        = pipe_stall || (!pipe_valid && !empty);
  assign push       = ll_valid && ll_ready && (ll_rd != 5'd0);

  always_comb begin
    alive_d   = alive_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    age_d     = '0;
    wr_en_d   = 1'b0;
    wr_rd_d   = 5'd0;
    wr_data_d = 32'd0;
    err_d     = err_q || (pipe_stall && pipe_valid);

    if (!empty && !pop)
      age_d = (age_q == GW'(STARVE_LIMIT)) ? age_q : age_q + GW'(1);

    if (pipe_issue) begin
      wr_en_d   = 1'b1;
      wr_rd_d   = pipe_rd;
      wr_data_d = pipe_data;
      // WAW kill of older queued writes to the same register
      for (int i = 0; i < DEPTH; i++)
        if (ent_rd_q[i] == pipe_rd) alive_d[i] = 1'b0;
    end else if (pop) begin
      wr_en_d = alive_q[rptr_q];
      if (alive_q[rptr_q]) begin
        wr_rd_d   = ent_rd_q[rptr_q];
        wr_data_d = ent_data_q[rptr_q];
      end
    end

    if (pop) rptr_d = rptr_q + AW'(1);
    // Applied after the kill: a same-cycle push is younger and stays alive
    if (push) begin
      alive_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive_q   <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      age_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= 5'd0;
      wr_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      alive_q   <= alive_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // Payload storage needs no reset; validity lives in count/alive.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wptr_q]   <= ll_rd;
      ent_data_q[wptr_q] <= ll_data;
    end
  end

  // Returns {hit, data}. Entries are scanned oldest to youngest so the
  // youngest alive match wins; the output register is the fallback.
  function automatic logic [32:0] lookup(input logic [4:0] addr);
    logic [32:0]   r;
    logic [AW-1:0] idx;
    r = 33'd0;
    if (addr != 5'd0) begin
      if (wr_en_q && (wr_rd_q == addr)) r = {1'b1, wr_data_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rptr_q + AW'(i);
        if (((AW+1)'(i) < count_q) && alive_q[idx] && (ent_rd_q[idx] == addr))
          r = {1'b1, ent_data_q[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd_rs_hit, fwd_rs_data} = lookup(fwd_rs);
    {fwd_rt_hit, fwd_rt_data} = lookup(fwd_rt);
  end

  assign regWrite      = wr_en_q;
  assign rd            = wr_rd_q;
  assign writeData     = wr_data_q;
  assign pending_count = count_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed steps followed by random traffic, all
// compared against a queue-based reference model of the write-port rules.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 4;
  localparam int AW           = 2;
  localparam int STARVE_LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        pipe_stall;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        regWrite;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic [4:0]  fwd_rs = '0, fwd_rt = '0;
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;
  logic [AW:0] pending_count;
  logic        err_sticky;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .regWrite(regWrite), .rd(rd), .writeData(writeData),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .pending_count(pending_count), .err_sticky(err_sticky)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        alive;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];   // pending long-latency writes, oldest first
  int          m_age;
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_err;

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    exp_q.delete();
    m_age = 0;
    m_rw  = 1'b0;
    m_rd  = '0;
    m_wd  = '0;
    m_err = 1'b0;
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] a);
    if (a == 5'd0) return 33'd0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].alive && exp_q[i].rd == a) return {1'b1, exp_q[i].data};
    if (m_rw && m_rd == a) return {1'b1, m_wd};
    return 33'd0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive after the falling edge, compare, then advance the model
  // to what the next rising edge should produce.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [4:0] frs, input logic [4:0] frt);
    logic        stall, pop, issue, push;
    logic [32:0] f;
    ent_t        h, n;
    int          sz;
    @(negedge clk);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    ll_valid = lv; ll_rd = lrd; ll_data = ld;
    fwd_rs = frs; fwd_rt = frt;
    #1;
    sz    = exp_q.size();
    stall = (sz > 0) && (m_age == STARVE_LIMIT);
    chk("pipe_stall", 32'(pipe_stall), 32'(stall));
    chk("ll_ready", 32'(ll_ready), 32'(sz < DEPTH));
    chk("pending_count", 32'(pending_count), 32'(sz));
    chk("regWrite", 32'(regWrite), 32'(m_rw));
    if (m_rw) begin
      chk("rd", 32'(rd), 32'(m_rd));
      chk("writeData", writeData, m_wd);
    end
    chk("err_sticky", 32'(err_sticky), 32'(m_err));
    f = model_fwd(frs);
    chk("fwd_rs_hit", 32'(fwd_rs_hit), 32'(f[32]));
    chk("fwd_rs_data", fwd_rs_data, f[31:0]);
    f = model_fwd(frt);
    chk("fwd_rt_hit", 32'(fwd_rt_hit), 32'(f[32]));
    chk("fwd_rt_data", fwd_rt_data, f[31:0]);

    pop   = stall || (!pv && sz > 0);
    issue = !stall && pv && prd != 5'd0;
    push  = lv && (sz < DEPTH) && lrd != 5'd0;
    if (stall && pv) m_err = 1'b1;
    m_rw = 1'b0; m_rd = '0; m_wd = '0;
    if (issue) begin
      m_rw = 1'b1; m_rd = prd; m_wd = pd;
      foreach (exp_q[i]) if (exp_q[i].rd == prd) exp_q[i].alive = 1'b0;
    end else if (pop) begin
      h = exp_q.pop_front();
      if (h.alive) begin
        m_rw = 1'b1; m_rd = h.rd; m_wd = h.data;
      end
    end
    if (sz == 0 || pop) m_age = 0;
    else if (m_age < STARVE_LIMIT) m_age++;
    if (push) begin
      n.alive = 1'b1; n.rd = lrd; n.data = ld;
      exp_q.push_back(n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic pulse_reset();
    @(negedge clk);
    pipe_valid = 0; ll_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_regWrite", 32'(regWrite), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_pending_count", 32'(pending_count), 0);
    chk("rst_ll_ready", 32'(ll_ready), 1);
    chk("rst_pipe_stall", 32'(pipe_stall), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    pulse_reset();

    // Pipe only: rd=5 appears one cycle later; rd=0 gives no write.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    step(1, 0, 32'h0BAD0BAD, 0, 0, 0, 5, 0);
    idle(2);

    // Idle ll: rd=7 written two edges after the handshake; rd=0 discarded.
    step(0, 0, 0, 1, 7, 32'h12345678, 7, 0);
    idle(3);
    step(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    idle(2);

    // Contention and starvation: pipe busy every cycle, FIFO fills, head
    // eventually forces a drain while pipe_valid is still held.
    for (int i = 0; i < 5; i++)
      step(1, 1, 32'h100 + i, 1, 5'(12 + i), 32'h200 + i, 5'(12 + i), 13);
    for (int i = 0; i < 24; i++)
      step(1, 1, 32'h300 + i, 0, 0, 0, 14, 15);
    idle(6);
    pulse_reset();

    // WAW kill: queued rd=9 is overridden by a pipe write to rd=9.
    step(1, 2, 32'h2, 1, 9, 32'h1111, 9, 0);
    step(1, 9, 32'hAAAA, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 9);
    step(0, 0, 0, 0, 0, 0, 9, 9);
    idle(2);

    // Forwarding order: the younger of two rd=3 entries wins.
    step(1, 4, 32'h4, 1, 3, 32'h1, 3, 0);
    step(1, 4, 32'h4, 1, 3, 32'h2, 3, 0);
    step(0, 0, 0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0, 0, 3, 3);
    step(0, 0, 0, 0, 0, 0, 3, 3);
    idle(2);

    // Reset mid-stream: three queued entries and a live output write.
    for (int i = 0; i < 3; i++)
      step(1, 6, 32'h600 + i, 1, 5'(20 + i), 32'h700 + i, 0, 0);
    step(1, 6, 32'h6FF, 0, 0, 0, 20, 6);
    pulse_reset();
    idle(3);

    // Random traffic over a small register range to provoke collisions.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
